// File: rtl/unary_stream_tx.sv
// Serialises two binary operands into beat-aligned unary (thermometer) streams,
// then holds a write phase so the downstream unary adder can emit its count.
module unary_stream_tx #(
    parameter int FRAME_LEN = 16,
    parameter int CW        = 5,
    parameter int DRAIN_LEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] val_a,
    input  logic [CW-1:0] val_b,
    output logic          A,
    output logic          B,
    output logic          en,
    output logic          read_or_write,
    output logic          busy,
    output logic          done
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [CW-1:0] FRAME_MAX  = CW'(FRAME_LEN);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_LEN - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_beat;
    logic [DW-1:0] r_drain;
    logic [CW-1:0] r_capA;
    logic [CW-1:0] r_capB;
    logic          r_A;
    logic          r_B;
    logic          r_en;
    logic          r_rw;
    logic          r_busy;
    logic          r_done;

    state_t        w_stateNext;
    logic [BW-1:0] w_beatNext;
    logic [DW-1:0] w_drainNext;
    logic [CW-1:0] w_capANext;
    logic [CW-1:0] w_capBNext;
    logic          w_sendBeat;
    logic          w_aNext;
    logic          w_bNext;
    logic          w_enNext;
    logic          w_rwNext;
    logic          w_busyNext;
    logic          w_doneNext;

    function automatic logic [CW-1:0] saturate(input logic [CW-1:0] v);
        return (v > FRAME_MAX) ? FRAME_MAX : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_drain <= '0;
            r_capA  <= '0;
            r_capB  <= '0;
            r_A     <= 1'b0;
            r_B     <= 1'b0;
            r_en    <= 1'b0;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_beat  <= w_beatNext;
            r_drain <= w_drainNext;
            r_capA  <= w_capANext;
            r_capB  <= w_capBNext;
            r_A     <= w_aNext;
            r_B     <= w_bNext;
            r_en    <= w_enNext;
            r_rw    <= w_rwNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
        end
    end

    // Outputs are computed from the next beat index so beat 0 appears right after acceptance.
    always_comb begin
        w_stateNext = r_state;
        w_beatNext  = r_beat;
        w_drainNext = r_drain;
        w_capANext  = r_capA;
        w_capBNext  = r_capB;
        w_sendBeat  = 1'b0;
        w_aNext     = 1'b0;
        w_bNext     = 1'b0;
        w_enNext    = 1'b0;
        w_rwNext    = 1'b0;
        w_busyNext  = 1'b0;
        w_doneNext  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_stateNext = SEND;
                    w_beatNext  = '0;
                    w_capANext  = saturate(val_a);
                    w_capBNext  = saturate(val_b);
                    w_sendBeat  = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_beat == LAST_BEAT) begin
                    w_stateNext = DRAIN;
                    w_drainNext = '0;
                    w_rwNext    = 1'b1;
                    w_busyNext  = 1'b1;
                end else begin
                    w_beatNext = r_beat + 1'b1;
                    w_sendBeat = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_drain == LAST_DRAIN) begin
                    w_stateNext = IDLE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_drainNext = r_drain + 1'b1;
                    w_rwNext    = 1'b1;
                    w_busyNext  = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase

        if (w_sendBeat) begin
            w_enNext   = 1'b1;
            w_busyNext = 1'b1;
            w_aNext    = (CW'(w_beatNext) < w_capANext);
            w_bNext    = (CW'(w_beatNext) < w_capBNext);
        end
    end

    assign A             = r_A;
    assign B             = r_B;
    assign en            = r_en;
    assign read_or_write = r_rw;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_unary_stream_tx.sv
// Directed scoreboard bench for unary_stream_tx: expected output vectors are queued
// when a frame is started and popped one per cycle as the DUT produces them.
module tb_unary_stream_tx;

    localparam int FRAME_LEN = 16;
    localparam int CW        = 5;
    localparam int DRAIN_LEN = 32;
    localparam int FRAME_CYC = FRAME_LEN + DRAIN_LEN + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] val_a;
    logic [CW-1:0] val_b;
    logic          A;
    logic          B;
    logic          en;
    logic          read_or_write;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    // Vector order: {en, A, B, read_or_write, busy, done}
    logic [5:0] expQ[$];

    logic       adderClear;
    logic [7:0] adderCount;

    unary_stream_tx #(
        .FRAME_LEN(FRAME_LEN),
        .CW(CW),
        .DRAIN_LEN(DRAIN_LEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .val_a(val_a),
        .val_b(val_b),
        .A(A),
        .B(B),
        .en(en),
        .read_or_write(read_or_write),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural downstream unary adder: accumulates ones while streaming.
    always_ff @(posedge clk) begin
        if (!rst_n || adderClear)
            adderCount <= 8'd0;
        else if (en && !read_or_write)
            adderCount <= adderCount + 8'(A) + 8'(B);
    end

    function automatic logic [5:0] frameEntry(input int sa, input int sb, input int i);
        if (i < FRAME_LEN)
            return {1'b1, (i < sa), (i < sb), 1'b0, 1'b1, 1'b0};
        else if (i < FRAME_LEN + DRAIN_LEN)
            return 6'b000110;
        else
            return 6'b000001;
    endfunction

    task automatic pushFrame(input int a, input int b, input int n);
        int sa;
        int sb;
        sa = (a > FRAME_LEN) ? FRAME_LEN : a;
        sb = (b > FRAME_LEN) ? FRAME_LEN : b;
        for (int i = 0; i < n; i++)
            expQ.push_back(frameEntry(sa, sb, i));
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++)
            expQ.push_back(6'b000000);
    endtask

    task automatic checkOutput(input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {en, A, B, read_or_write, busy, done};
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL %s scoreboard empty, observed=%b", tag, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput(tag);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic ab, input int a, input int b);
        start = s;
        abort = ab;
        val_a = CW'(a);
        val_b = CW'(b);
    endtask

    initial begin
        rst_n      = 1'b0;
        adderClear = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0);

        // Reset state
        pushIdle(2);
        runCycles(2, "reset");
        rst_n = 1'b1;
        pushIdle(1);
        runCycles(1, "idle");

        // Basic frame 3/5
        applyStimulus(1'b1, 1'b0, 3, 5);
        pushFrame(3, 5, FRAME_CYC);
        runCycles(1, "basic");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(FRAME_CYC - 1, "basic");
        pushIdle(2);
        runCycles(2, "basicIdle");

        // Bounds: zero and exactly FRAME_LEN
        applyStimulus(1'b1, 1'b0, 0, 16);
        pushFrame(0, 16, FRAME_CYC);
        runCycles(1, "bounds0_16");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(FRAME_CYC - 1, "bounds0_16");

        // Saturation, plus start/value changes while busy must be ignored
        applyStimulus(1'b1, 1'b0, 31, 9);
        pushFrame(31, 9, FRAME_CYC);
        runCycles(1, "saturate");
        applyStimulus(1'b1, 1'b0, 2, 2);
        runCycles(20, "startWhileBusy");
        applyStimulus(1'b0, 1'b0, 2, 2);
        runCycles(FRAME_CYC - 21, "saturate");

        // Back-to-back: start held through the done cycle
        applyStimulus(1'b1, 1'b0, 3, 5);
        pushFrame(3, 5, FRAME_CYC);
        pushFrame(3, 5, FRAME_CYC);
        runCycles(FRAME_CYC, "b2bFirst");
        runCycles(1, "b2bSecond");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(FRAME_CYC - 1, "b2bSecond");

        // Abort during beat 7
        applyStimulus(1'b1, 1'b0, 4, 12);
        pushFrame(4, 12, 8);
        pushIdle(4);
        runCycles(1, "abortFrame");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(7, "abortFrame");
        abort = 1'b1;
        runCycles(1, "abortOut");
        abort = 1'b0;
        runCycles(3, "abortNoDone");

        // Full frame after abort
        applyStimulus(1'b1, 1'b0, 10, 6);
        pushFrame(10, 6, FRAME_CYC);
        runCycles(1, "afterAbort");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(FRAME_CYC - 1, "afterAbort");

        // Reset in the middle of DRAIN
        applyStimulus(1'b1, 1'b0, 3, 5);
        pushFrame(3, 5, FRAME_LEN + 10);
        pushIdle(4);
        runCycles(1, "midDrain");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(FRAME_LEN + 9, "midDrain");
        rst_n = 1'b0;
        runCycles(1, "resetOut");
        rst_n = 1'b1;
        runCycles(3, "resetNoDone");

        // abort and start together in IDLE
        applyStimulus(1'b1, 1'b1, 7, 7);
        pushIdle(4);
        runCycles(2, "abortStartIdle");
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(2, "abortStartIdle");

        // Loopback into the unary adder: 7 + 9 ones
        adderClear = 1'b1;
        applyStimulus(1'b1, 1'b0, 7, 9);
        pushFrame(7, 9, FRAME_CYC);
        runCycles(1, "loopback");
        adderClear = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0);
        runCycles(FRAME_LEN, "loopback");
        checks++;
        assert (read_or_write === 1'b1 && adderCount === 8'd16) else begin
            failures++;
            $error("[TB] FAIL adderCount observed=%0d rw=%b expected=16 rw=1", adderCount, read_or_write);
        end
        runCycles(FRAME_CYC - FRAME_LEN - 1, "loopback");

        checks++;
        assert (expQ.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboardDrain observed=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
